// File: rtl/rv32i_pkg.sv
// ============================================================================
// rv32i_pkg : RV32I opcode constants and immediate-format encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package rv32i_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_t;

endpackage

`default_nettype wire

// File: rtl/imm_gen.sv
// ============================================================================
// imm_gen : combinational RV32I immediate assembly, sign-extended to size bits
// Rev 1.0
// ============================================================================
`default_nettype none

module imm_gen
  import rv32i_pkg::*;
#(
  parameter int size = 32
) (
  input  logic [31:0]     instr,
  input  imm_fmt_t        fmt,
  output logic [size-1:0] imm
);

  logic [31:0] raw;
  logic        unused_opcode;

  // The opcode field only selects the format upstream; it never enters the value.
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    raw = 32'd0;
    case (fmt)
      IMM_I:   raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   raw = {instr[31:12], 12'd0};
      IMM_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: raw = 32'd0;
    endcase
  end

  generate
    if (size > 32) begin : g_ext
      assign imm = {{(size-32){raw[31]}}, raw};
    end else begin : g_noext
      assign imm = raw[size-1:0];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
// ============================================================================
// id_ex_operand_stage : ID-stage opcode decode plus the ID/EX pipeline register
// Rev 1.0
// ============================================================================
`default_nettype none

module id_ex_operand_stage
  import rv32i_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [31:0]     instr_i,
  input  logic [size-1:0] pc_i,
  input  logic [size-1:0] data2_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            valid_o,
  output logic            B_Sel,
  output logic [size-1:0] imm,
  output logic [size-1:0] data2,
  output logic [size-1:0] pc_o,
  output logic [4:0]      rd_o,
  output logic            illegal_o
);

  imm_fmt_t        fmt;
  logic            bsel_d;
  logic            illegal_d;
  logic            rd_zero;
  logic [size-1:0] imm_d;

  always_comb begin
    fmt       = IMM_NONE;
    bsel_d    = 1'b0;
    illegal_d = 1'b0;
    rd_zero   = 1'b0;
    case (instr_i[6:0])
      OPC_R:      ;
      OPC_OPIMM:  begin fmt = IMM_I; bsel_d = 1'b1; end
      OPC_LOAD:   begin fmt = IMM_I; bsel_d = 1'b1; end
      OPC_STORE:  begin fmt = IMM_S; bsel_d = 1'b1; rd_zero = 1'b1; end
      OPC_BRANCH: begin fmt = IMM_B; rd_zero = 1'b1; end
      OPC_JALR:   begin fmt = IMM_I; bsel_d = 1'b1; end
      OPC_JAL:    begin fmt = IMM_J; bsel_d = 1'b1; end
      OPC_LUI:    begin fmt = IMM_U; bsel_d = 1'b1; end
      OPC_AUIPC:  begin fmt = IMM_U; bsel_d = 1'b1; end
      OPC_FENCE:  fmt = IMM_I;
      OPC_SYSTEM: fmt = IMM_I;
      default:    illegal_d = 1'b1;
    endcase
  end

  imm_gen #(
    .size (size)
  ) u_imm_gen (
    .instr (instr_i),
    .fmt   (fmt),
    .imm   (imm_d)
  );

  // Flush outranks stall; an invalid ID slot is captured as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o   <= 1'b0;
      B_Sel     <= 1'b0;
      imm       <= '0;
      data2     <= '0;
      pc_o      <= '0;
      rd_o      <= 5'd0;
      illegal_o <= 1'b0;
    end else if (flush_i || (!stall_i && !valid_i)) begin
      valid_o   <= 1'b0;
      B_Sel     <= 1'b0;
      imm       <= '0;
      data2     <= '0;
      pc_o      <= '0;
      rd_o      <= 5'd0;
      illegal_o <= 1'b0;
    end else if (!stall_i) begin
      valid_o   <= 1'b1;
      B_Sel     <= bsel_d;
      imm       <= imm_d;
      data2     <= data2_i;
      pc_o      <= pc_i;
      rd_o      <= rd_zero ? 5'd0 : instr_i[11:7];
      illegal_o <= illegal_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
// ============================================================================
// tb_id_ex_operand_stage : randomized and directed checks against a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_operand_stage;

  typedef struct packed {
    logic        valid;
    logic        bsel;
    logic [31:0] imm;
    logic [31:0] data2;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        ill;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] instr_i = 32'd0;
  logic [31:0] pc_i = 32'd0;
  logic [31:0] data2_i = 32'd0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_o, B_Sel, illegal_o;
  logic [31:0] imm, data2, pc_o;
  logic [4:0]  rd_o;

  int    compared = 0;
  int    mismatched = 0;
  outs_t exp_s = '0;
  outs_t act;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.size(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (valid_i),
    .instr_i   (instr_i),
    .pc_i      (pc_i),
    .data2_i   (data2_i),
    .stall_i   (stall_i),
    .flush_i   (flush_i),
    .valid_o   (valid_o),
    .B_Sel     (B_Sel),
    .imm       (imm),
    .data2     (data2),
    .pc_o      (pc_o),
    .rd_o      (rd_o),
    .illegal_o (illegal_o)
  );

  assign act = '{valid: valid_o, bsel: B_Sel, imm: imm, data2: data2, pc: pc_o, rd: rd_o, ill: illegal_o};

  // Reference: immediate value from the ISA field rules using arithmetic shifts.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins, input int f);
    logic signed [31:0] s;
    s = ins;
    case (f)
      1: return 32'(s >>> 20);
      2: return (32'(s >>> 25) << 5) | 32'(ins[11:7]);
      3: return (32'(s >>> 31) << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      4: return ins & 32'hFFFF_F000;
      5: return (32'(s >>> 31) << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      default: return 32'd0;
    endcase
  endfunction

  function automatic outs_t model(input outs_t cur, input logic fl, input logic st, input logic v,
                                  input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] d2);
    outs_t n;
    int    f;
    logic  b, il, nord;
    if (fl) return '0;
    if (st) return cur;
    if (!v) return '0;
    f = 0; b = 0; il = 0; nord = 0;
    case (ins[6:0])
      7'h33: ;
      7'h13, 7'h03, 7'h67: begin f = 1; b = 1; end
      7'h23: begin f = 2; b = 1; nord = 1; end
      7'h63: begin f = 3; nord = 1; end
      7'h6F: begin f = 5; b = 1; end
      7'h37, 7'h17: begin f = 4; b = 1; end
      7'h0F, 7'h73: f = 1;
      default: il = 1;
    endcase
    n.valid = 1'b1;
    n.bsel  = b;
    n.imm   = ref_imm(ins, f);
    n.data2 = d2;
    n.pc    = pc;
    n.rd    = nord ? 5'd0 : ins[11:7];
    n.ill   = il;
    return n;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] d2, input logic st, input logic fl);
    valid_i = v; instr_i = ins; pc_i = pc; data2_i = d2; stall_i = st; flush_i = fl;
    @(posedge clk);
    #1;
    exp_s = model(exp_s, fl, st, v, ins, pc, d2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    compared++;
    if (act !== outs_t'(0)) begin
      mismatched++;
      $display("FAIL reset: got %h want 0", act);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_s = '0;
  endtask

  task automatic test_directed();
    logic [31:0] ins [7] = '{32'hFFF00093, 32'h002081B3, 32'h0020A423, 32'hFE000EE3,
                             32'h123452B7, 32'h001000EF, 32'h00000013};
    logic [31:0] ei  [7] = '{32'hFFFFFFFF, 32'h0, 32'h8, 32'hFFFFFFFC, 32'h12345000, 32'h800, 32'h0};
    logic        eb  [7] = '{1, 0, 1, 0, 1, 1, 1};
    logic [4:0]  er  [7] = '{1, 3, 0, 0, 5, 1, 0};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, ins[i], 32'h1000 + 32'(i * 4), 32'h00001234, 1'b0, 1'b0);
      compared++;
      if ({imm, B_Sel, rd_o, valid_o, illegal_o, data2} !== {ei[i], eb[i], er[i], 1'b1, 1'b0, 32'h00001234}) begin
        mismatched++;
        $display("FAIL directed[%0d]: got imm=%h bsel=%b rd=%0d v=%b ill=%b d2=%h want imm=%h bsel=%b rd=%0d",
                 i, imm, B_Sel, rd_o, valid_o, illegal_o, data2, ei[i], eb[i], er[i]);
      end
      compared++;
      if (act !== exp_s) begin
        mismatched++;
        $display("FAIL directed_model[%0d]: got %h want %h", i, act, exp_s);
      end
    end
  endtask

  task automatic test_stall_flush();
    outs_t held;
    drive(1'b1, 32'hFFF00093, 32'h2000, 32'hA5A5A5A5, 1'b0, 1'b0);
    held = act;
    compared++;
    if (held !== exp_s) begin
      mismatched++;
      $display("FAIL stall_capture: got %h want %h", held, exp_s);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, $urandom, $urandom, 1'b1, 1'b0);
      compared++;
      if (act !== exp_s) begin
        mismatched++;
        $display("FAIL stall_hold[%0d]: got %h want %h", i, act, exp_s);
      end
    end
    drive(1'b1, 32'h123452B7, 32'h3000, 32'h5, 1'b1, 1'b1);
    compared++;
    if ({valid_o, B_Sel, imm, data2, pc_o, rd_o, illegal_o} !== 104'd0) begin
      mismatched++;
      $display("FAIL stall_flush: got %h want 0", act);
    end
    drive(1'b1, 32'h0020A423, 32'h3004, 32'h77, 1'b0, 1'b0);
    compared++;
    if (act !== exp_s) begin
      mismatched++;
      $display("FAIL stall_release: got %h want %h", act, exp_s);
    end
  endtask

  task automatic test_illegal_async_reset();
    drive(1'b1, 32'h0000007F, 32'h4000, 32'h99, 1'b0, 1'b0);
    compared++;
    if ({illegal_o, B_Sel, valid_o, imm} !== {1'b1, 1'b0, 1'b1, 32'd0} || act !== exp_s) begin
      mismatched++;
      $display("FAIL illegal: got %h want %h", act, exp_s);
    end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (act !== outs_t'(0)) begin
      mismatched++;
      $display("FAIL async_reset: got %h want 0", act);
    end
    exp_s = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [6:0] opcs [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67,
                              7'h6F, 7'h37, 7'h17, 7'h0F, 7'h73, 7'h00};
    logic [31:0] ins;
    int k;
    for (int i = 0; i < 300; i++) begin
      ins = $urandom;
      k = $urandom_range(0, 11);
      ins[6:0] = (k == 11) ? 7'($urandom) : opcs[k];
      drive($urandom_range(0, 4) != 0, ins, $urandom, $urandom,
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      compared++;
      if (act !== exp_s) begin
        mismatched++;
        $display("FAIL random[%0d] instr=%h: got %h want %h", i, ins, act, exp_s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall_flush();
    test_illegal_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
